four_way_link_splitter: RTL

Buffered one-to-four link fan-out: accepts packets from one input link, holds them in a small FIFO, and delivers each packet to every output link selected by a software-configured enable mask, completing only when all selected outputs have acknowledged. It is the distribution end of the interconnect, paired with the four-to-one link combiner on the gathering side. Unlike the combiner it is sequential: it decouples the input handshake from the outputs and supports multicast to several outputs.

---
 rtl/four_way_link_splitter_pkg.sv | 27 ++
 rtl/link_if.sv | 11 +
 rtl/link_fifo.sv | 58 +++++
 rtl/four_way_link_splitter.sv | 110 +++++++++++
 4 files changed

// File: rtl/four_way_link_splitter_pkg.sv
// Shared interconnect types for the link splitter: packet payload, idle
// packet value and dispatch FSM states.
package four_way_link_splitter_pkg;

  localparam int unsigned NUM_OUTPUTS = 4;
  localparam int unsigned ID_W        = 4;
  localparam int unsigned PAYLOAD_W   = 16;

  typedef struct packed {
    logic [ID_W-1:0]      id;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;

  localparam packet_t NULL_PACKET = '0;

  typedef enum logic {
    IDLE     = 1'b0,
    DISPATCH = 1'b1
  } splitter_state_t;

  // True when every still-pending output is acknowledging this cycle.
  function automatic logic dispatch_done(input logic [NUM_OUTPUTS-1:0] pending,
                                         input logic [NUM_OUTPUTS-1:0] acks);
    return (pending & ~acks) == '0;
  endfunction

endpackage

// File: rtl/link_if.sv
// Point-to-point req/ack link carrying one packet per transfer.
interface link_if;
  import four_way_link_splitter_pkg::*;

  logic    req;
  logic    ack;
  packet_t packet;

  modport sender   (output req, output packet, input ack);
  modport receiver (input req, input packet, output ack);
endinterface

// File: rtl/link_fifo.sv
// Small circular packet FIFO shared by the buffered interconnect blocks.
// Head packet is visible combinationally from the storage array.
module link_fifo
  import four_way_link_splitter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         pkt_t = packet_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq,
  input  logic                     deq,
  input  pkt_t                     enq_packet,
  output pkt_t                     head_packet,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  pkt_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head_packet = mem[rd_ptr];
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(DEPTH));

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= enq_packet;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      end
      if (deq) begin
        rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      end
      case ({enq, deq})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/four_way_link_splitter.sv
// Buffered one-to-four link fan-out: queues input packets and multicasts the
// head to every output selected by the mask captured at load time.
module four_way_link_splitter
  import four_way_link_splitter_pkg::*;
#(
  parameter int unsigned BUFFER_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_OUTPUTS-1:0] output_enable_mask,
  link_if.receiver               input_link,
  link_if.sender                 output_link_0,
  link_if.sender                 output_link_1,
  link_if.sender                 output_link_2,
  link_if.sender                 output_link_3
);

  localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH) + 1;

  splitter_state_t        state;
  logic [NUM_OUTPUTS-1:0] pending;

  logic                   empty;
  logic                   full;
  logic [CNT_W-1:0]       count;
  packet_t                head_packet;

  logic                   enq_c;
  logic                   deq_c;
  logic                   done_c;
  logic [NUM_OUTPUTS-1:0] acks_c;
  logic [NUM_OUTPUTS-1:0] req_c;
  packet_t                out_packet_c [NUM_OUTPUTS];

  // Input ack depends only on registered occupancy, never on output acks.
  assign input_link.ack = ~full & ~reset;
  assign enq_c          = input_link.req & input_link.ack;

  assign acks_c = {output_link_3.ack, output_link_2.ack,
                   output_link_1.ack, output_link_0.ack};
  assign done_c = dispatch_done(pending, acks_c);
  assign deq_c  = (state == DISPATCH) && done_c;

  link_fifo #(
    .DEPTH (BUFFER_DEPTH),
    .pkt_t (packet_t)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .enq         (enq_c),
    .deq         (deq_c),
    .enq_packet  (input_link.packet),
    .head_packet (head_packet),
    .empty       (empty),
    .full        (full),
    .count       (count)
  );

  // Dispatch FSM; reload back-to-back only when a second entry is already queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty && (output_enable_mask != '0)) begin
            pending <= output_enable_mask;
            state   <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (done_c) begin
            if ((count > CNT_W'(1)) && (output_enable_mask != '0)) begin
              pending <= output_enable_mask;
            end else begin
              pending <= '0;
              state   <= IDLE;
            end
          end else begin
            pending <= pending & ~acks_c;
          end
        end
        default: begin
          pending <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Requests follow the pending register, forced low during reset.
  assign req_c = pending & {NUM_OUTPUTS{~reset}};

  always_comb begin
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      out_packet_c[i] = req_c[i] ? head_packet : NULL_PACKET;
    end
  end

  assign output_link_0.req    = req_c[0];
  assign output_link_1.req    = req_c[1];
  assign output_link_2.req    = req_c[2];
  assign output_link_3.req    = req_c[3];
  assign output_link_0.packet = out_packet_c[0];
  assign output_link_1.packet = out_packet_c[1];
  assign output_link_2.packet = out_packet_c[2];
  assign output_link_3.packet = out_packet_c[3];

endmodule
